// File: rtl/apb_pkg.sv
// Shared types for the APB initiator: bus widths, FSM states, command bundle.
package apb_pkg;

    localparam int APB_ADDR_W = 8;
    localparam int APB_DATA_W = 21;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS
    } apb_state_e;

    typedef struct packed {
        logic                  write;
        logic [APB_ADDR_W-1:0] addr;
        logic [APB_DATA_W-1:0] wdata;
    } apb_cmd_t;

endpackage

// File: rtl/apb_cmd_buf.sv
// One-entry command holding register; push and pop are mutually exclusive.
module apb_cmd_buf
    import apb_pkg::*;
(
    input  logic     clk,
    input  logic     rst_n,
    input  logic     push,
    input  logic     pop,
    input  apb_cmd_t din,
    output logic     valid,
    output apb_cmd_t dout
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            dout  <= '0;
        end else begin
            if (pop) begin
                valid <= 1'b0;
            end
            if (push) begin
                valid <= 1'b1;
                dout  <= din;
            end
        end
    end

endmodule

// File: rtl/apb_master.sv
// APB initiator: valid/ready commands to SETUP/ACCESS transfers, one-entry buffer.
// Optional ACCESS timeout abort enabled by defining APB_MASTER_TIMEOUT_EN.
module apb_master
    import apb_pkg::*;
#(
    parameter int ADDR_W  = APB_ADDR_W,
    parameter int DATA_W  = APB_DATA_W,
    parameter int TIMEOUT = 16
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              PSEL,
    output logic              PENABLE,
    output logic [ADDR_W-1:0] PADDR,
    output logic              PWRITE,
    output logic [DATA_W-1:0] PWDATA,
    input  logic              PREADY,
    input  logic [DATA_W-1:0] PRDATA
);

    apb_state_e state;
    apb_cmd_t   apb_q;
    apb_cmd_t   in_cmd;
    apb_cmd_t   buf_cmd;
    apb_cmd_t   nxt_cmd;
    logic       buf_valid;
    logic       fire;
    logic       tmo;
    logic       done;
    logic       take;
    logic       nxt_ok;
    logic       push;
    logic       pop;

    assign cmd_ready = !buf_valid;
    assign fire      = cmd_valid && cmd_ready;

    always_comb begin
        in_cmd       = '0;
        in_cmd.write = cmd_write;
        in_cmd.addr  = cmd_addr;
        in_cmd.wdata = cmd_wdata;
    end

    // Completion frees the bus this cycle, so a new command skips the buffer
    assign done   = (state == ACCESS) && (PREADY || tmo);
    assign take   = (state == IDLE) || done;
    assign nxt_ok = buf_valid || fire;
    assign nxt_cmd = buf_valid ? buf_cmd : in_cmd;
    assign pop    = buf_valid && take;
    assign push   = fire && !take;

    apb_cmd_buf u_buf (
        .clk   (PCLK),
        .rst_n (PRESET),
        .push  (push),
        .pop   (pop),
        .din   (in_cmd),
        .valid (buf_valid),
        .dout  (buf_cmd)
    );

    assign PADDR  = apb_q.addr;
    assign PWRITE = apb_q.write;
    assign PWDATA = apb_q.wdata;

`ifdef APB_MASTER_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] wcnt;
    logic             err_q;

    assign tmo     = (state == ACCESS) && !PREADY
                     && (wcnt == CNT_W'(TIMEOUT - 1));
    assign rsp_err = err_q;

    always_ff @(posedge PCLK or negedge PRESET) begin
        if (!PRESET) begin
            wcnt  <= '0;
            err_q <= 1'b0;
        end else begin
            err_q <= tmo;
            if (state == SETUP) begin
                wcnt <= '0;
            end else if (state == ACCESS && !PREADY) begin
                wcnt <= wcnt + 1'b1;
            end
        end
    end
`else
    assign tmo     = 1'b0;
    assign rsp_err = 1'b0;
`endif

    always_ff @(posedge PCLK or negedge PRESET) begin
        if (!PRESET) begin
            state     <= IDLE;
            apb_q     <= '0;
            PSEL      <= 1'b0;
            PENABLE   <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            rsp_valid <= done;
            unique case (state)
                IDLE: begin
                    if (nxt_ok) begin
                        apb_q <= nxt_cmd;
                        PSEL  <= 1'b1;
                        state <= SETUP;
                    end
                end
                SETUP: begin
                    PENABLE <= 1'b1;
                    state   <= ACCESS;
                end
                ACCESS: begin
                    if (done) begin
                        // Aborted transfers and writes report zero data
                        rsp_rdata <= (apb_q.write || !PREADY) ? '0 : PRDATA;
                        PENABLE   <= 1'b0;
                        if (nxt_ok) begin
                            apb_q <= nxt_cmd;
                            state <= SETUP;
                        end else begin
                            PSEL  <= 1'b0;
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    PSEL    <= 1'b0;
                    PENABLE <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_master.sv
// Self-checking bench for apb_master: directed timing cases plus randomized traffic.
module tb_apb_master;
    import apb_pkg::*;

    localparam int AW  = 8;
    localparam int DW  = 21;
    localparam int TMO = 16;
    localparam int NRND = 200;

    logic          PCLK = 1'b0;
    logic          PRESET = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_write = 1'b0;
    logic [AW-1:0] cmd_addr = '0;
    logic [DW-1:0] cmd_wdata = '0;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic          PSEL;
    logic          PENABLE;
    logic [AW-1:0] PADDR;
    logic          PWRITE;
    logic [DW-1:0] PWDATA;
    logic          PREADY;
    logic [DW-1:0] PRDATA;

    always #5 PCLK = ~PCLK;

    apb_master #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO)) dut (
        .PCLK      (PCLK),
        .PRESET    (PRESET),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .PSEL      (PSEL),
        .PENABLE   (PENABLE),
        .PADDR     (PADDR),
        .PWRITE    (PWRITE),
        .PWDATA    (PWDATA),
        .PREADY    (PREADY),
        .PRDATA    (PRDATA)
    );

    // Behavioural APB memory slave with programmable wait states
    logic [DW-1:0] smem [256];
    int  wcnt = 0;
    int  wlim = 0;
    int  pwait = 0;
    bit  rnd_wait = 1'b0;
    bit  hold_nr = 1'b0;

    assign PREADY = !hold_nr && PSEL && PENABLE && (wcnt == wlim);
    assign PRDATA = smem[PADDR];

    always @(posedge PCLK) begin
        if (PSEL && PENABLE && !PREADY) wcnt <= wcnt + 1;
        else wcnt <= 0;
        if (PSEL && !PENABLE)
            wlim <= rnd_wait ? int'($urandom_range(3, 0)) : pwait;
        if (PSEL && PENABLE && PREADY && PWRITE) smem[PADDR] <= PWDATA;
    end

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge PCLK);
    endtask

    // Reference model for random phase: memory image plus ordered response queue
    logic [DW-1:0] mmem [256];
    bit            mwr [256];
    logic [DW-1:0] exp_q [$];
    bit            use_q [$];

    initial begin
        int bad;
        int acc;
        int n;
        bit seen;
        logic [DW-1:0] x;
        for (int i = 0; i < 256; i++) begin
            mmem[i] = '0;
            mwr[i]  = 1'b0;
        end

        // Reset values
        tick();
        tick();
        chk("rst_psel", PSEL, 0);
        chk("rst_penable", PENABLE, 0);
        chk("rst_paddr", PADDR, 0);
        chk("rst_pwrite", PWRITE, 0);
        chk("rst_pwdata", PWDATA, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_rdata", rsp_rdata, 0);
        chk("rst_rsp_err", rsp_err, 0);
        chk("rst_cmd_ready", cmd_ready, 1);
        PRESET = 1'b1;
        tick();

        // Write, zero wait states
        pwait = 0;
        chk("wr_ready", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 8'h3A;
        cmd_wdata = 21'h1ABCDE;
        tick();
        cmd_valid = 1'b0;
        chk("wr_setup_psel", PSEL, 1);
        chk("wr_setup_pen", PENABLE, 0);
        chk("wr_setup_addr", PADDR, 32'h3A);
        chk("wr_setup_wdata", PWDATA, 32'h1ABCDE);
        tick();
        chk("wr_acc_pen", PENABLE, 1);
        chk("wr_acc_addr", PADDR, 32'h3A);
        chk("wr_acc_wdata", PWDATA, 32'h1ABCDE);
        chk("wr_acc_rsp", rsp_valid, 0);
        tick();
        chk("wr_rsp_valid", rsp_valid, 1);
        chk("wr_rsp_err", rsp_err, 0);
        chk("wr_rsp_rdata", rsp_rdata, 0);

        // Idle stability after the write
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (PSEL || PENABLE || rsp_valid || PADDR != 8'h3A || !PWRITE
                || PWDATA != 21'h1ABCDE) bad++;
        end
        chk("idle_stable", bad, 0);
        chk("idle_addr", PADDR, 32'h3A);

        // Read with three wait states
        pwait = 3;
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 8'h3A;
        tick();
        cmd_valid = 1'b0;
        chk("rd_setup", {PSEL, PENABLE}, 2'b10);
        acc = 0;
        n = 1;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick();
            n++;
            if (PENABLE) acc++;
            if (rsp_valid) seen = 1'b1;
        end
        chk("rd_rsp_seen", seen, 1);
        chk("rd_access_cycles", acc, 4);
        chk("rd_rsp_cycle", n, 6);
        chk("rd_rdata", rsp_rdata, 32'h1ABCDE);

        // Back-to-back write then read of the same address
        pwait = 0;
        x = DW'($urandom);
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 8'h10;
        cmd_wdata = x;
        tick();
        chk("b2b_setup1", {PSEL, PENABLE}, 2'b10);
        chk("b2b_ready1", cmd_ready, 1);
        cmd_write = 1'b0;
        tick();
        chk("b2b_buffered", cmd_ready, 0);
        chk("b2b_acc1", {PSEL, PENABLE}, 2'b11);
        cmd_valid = 1'b0;
        tick();
        chk("b2b_setup2", {PSEL, PENABLE}, 2'b10);
        chk("b2b_wr_rsp", rsp_valid, 1);
        chk("b2b_addr2", {PWRITE, PADDR}, 32'h010);
        tick();
        chk("b2b_acc2", {PSEL, PENABLE}, 2'b11);
        chk("b2b_ready2", cmd_ready, 1);
        chk("b2b_no_rsp", rsp_valid, 0);
        tick();
        chk("b2b_rd_rsp", rsp_valid, 1);
        chk("b2b_rd_data", rsp_rdata, 32'(x));
        tick();
        chk("b2b_idle", PSEL, 0);

        // Reset while ACCESS is waiting, with a second command buffered
        pwait = 6;
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 8'h3A;
        tick();
        cmd_write = 1'b1;
        cmd_addr  = 8'h20;
        cmd_wdata = 21'h155555;
        tick();
        cmd_valid = 1'b0;
        chk("mrst_pre_pen", PENABLE, 1);
        chk("mrst_pre_buf", cmd_ready, 0);
        #2 PRESET = 1'b0;
        #1;
        chk("mrst_psel", PSEL, 0);
        chk("mrst_pen", PENABLE, 0);
        chk("mrst_ready", cmd_ready, 1);
        chk("mrst_rsp", rsp_valid, 0);
        tick();
        PRESET = 1'b1;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (rsp_valid || PSEL) bad++;
        end
        chk("mrst_quiet", bad, 0);
        chk("mrst_ready_after", cmd_ready, 1);
        chk("mrst_buf_dropped", {PWRITE, PADDR}, 32'h000);

        // Slave never ready
        hold_nr = 1'b1;
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 8'h3A;
        tick();
        cmd_valid = 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
        acc = 0;
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            tick();
            if (PENABLE) acc++;
            if (rsp_valid) seen = 1'b1;
        end
        chk("tmo_seen", seen, 1);
        chk("tmo_access_cycles", acc, TMO);
        chk("tmo_err", rsp_err, 1);
        chk("tmo_rdata", rsp_rdata, 0);
        chk("tmo_psel", PSEL, 0);
        hold_nr = 1'b0;
`else
        bad = 0;
        tick();
        for (int i = 0; i < 100; i++) begin
            tick();
            if (!(PSEL && PENABLE) || rsp_valid || rsp_err) bad++;
        end
        chk("notmo_hold", bad, 0);
        hold_nr = 1'b0;
        #2 PRESET = 1'b0;
        tick();
        PRESET = 1'b1;
        tick();
        chk("notmo_recover", PSEL, 0);
`endif

        // Randomized traffic against the reference model
        rnd_wait = 1'b1;
        begin
            int  sent;
            int  cyc;
            bit  rdy_prev;
            logic [DW-1:0] e;
            bit  u;
            sent = 0;
            cyc = 0;
            rdy_prev = cmd_ready;
            while ((sent < NRND || exp_q.size() > 0) && cyc < 20000) begin
                tick();
                cyc++;
                if (cmd_valid && rdy_prev) begin
                    if (cmd_write) begin
                        mmem[cmd_addr] = cmd_wdata;
                        mwr[cmd_addr] = 1'b1;
                        exp_q.push_back('0);
                        use_q.push_back(1'b1);
                    end else begin
                        exp_q.push_back(mmem[cmd_addr]);
                        use_q.push_back(mwr[cmd_addr]);
                    end
                    sent++;
                    cmd_valid = 1'b0;
                end
                if (rsp_valid) begin
                    if (exp_q.size() == 0) begin
                        chk("rnd_spurious", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        u = use_q.pop_front();
                        if (u) chk("rnd_rdata", rsp_rdata, 32'(e));
                        chk("rnd_err", rsp_err, 0);
                    end
                end
                if (!cmd_valid && sent < NRND && $urandom_range(3, 0) != 0) begin
                    cmd_valid = 1'b1;
                    cmd_write = 1'($urandom);
                    cmd_addr  = 8'h40 + 8'($urandom_range(15, 0));
                    cmd_wdata = DW'($urandom);
                end
                rdy_prev = cmd_ready;
            end
            chk("rnd_sent", sent, NRND);
            chk("rnd_drained", exp_q.size(), 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
